// File: rtl/recirc_pkg.sv
// ---------------------------------------------------------------------------
// recirc_pkg
//   Shared definitions for the recirculator control FSM.
//   - recircState_e : state encodings (RESET=0, INIT=1, IDLE=2, ACTIVE=3,
//                     ERROR=4), also driven on state_out
//   - RECIRC_THR_W  : default width of the FIFO almost-full/empty thresholds
//   - RECIRC_LANES  : number of FIFO lanes watched by the FSM
// ---------------------------------------------------------------------------
package recirc_pkg;

  localparam int RECIRC_THR_W = 3;
  localparam int RECIRC_LANES = 4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } recircState_e;

endpackage : recirc_pkg

// File: rtl/idle_debounce.sv
// ---------------------------------------------------------------------------
// idle_debounce
//   Counts consecutive clock edges spent in ACTIVE with every lane empty and
//   flags the edge on which the run reaches HOLD. Only built when the macro
//   RECIRC_IDLE_DEBOUNCE_EN is defined.
//
//   Parameters : HOLD     - all-empty edges needed before ACTIVE->IDLE
//   Ports      : clk      - clock
//                reset_L  - synchronous active-low reset
//                active   - FSM currently in ACTIVE
//                allEmpty - every lane FIFO reports empty
//                holdDone - this edge completes the HOLD-long empty run
// ---------------------------------------------------------------------------
`ifdef RECIRC_IDLE_DEBOUNCE_EN
module idle_debounce #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic reset_L,
  input  logic active,
  input  logic allEmpty,
  output logic holdDone
);

  localparam int CntW = $clog2(HOLD + 1);

  logic [CntW-1:0] holdCount;

  // Run length of all-empty edges; saturates at HOLD and drops back to zero
  // as soon as a lane has data or the FSM is no longer in ACTIVE.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      holdCount <= '0;
    end else if (active && allEmpty) begin
      if (holdCount != CntW'(HOLD)) begin
        holdCount <= holdCount + 1'b1;
      end
    end else begin
      holdCount <= '0;
    end
  end

  // The current edge is the HOLD-th one when HOLD-1 have already been seen.
  assign holdDone = active && allEmpty && (holdCount >= CntW'(HOLD - 1));

endmodule : idle_debounce
`endif

// File: rtl/recirc_fsm.sv
// ---------------------------------------------------------------------------
// recirc_fsm
//   Moore control FSM for the lane recirculator. Programs the FIFO
//   almost-full/almost-empty thresholds while in INIT, selects the idle path
//   while every lane is drained, and latches per-lane FIFO errors.
//
//   Optional feature (macro RECIRC_IDLE_DEBOUNCE_EN): ACTIVE->IDLE waits for
//   IDLE_HOLD consecutive all-empty edges instead of the first one.
//
//   Parameters : THR_W         - threshold width
//                IDLE_HOLD     - debounce length (debounce build only)
//   Ports      : clk           - clock, all state updates on posedge
//                reset_L       - synchronous active-low reset
//                init          - request INIT / program thresholds
//                thr_af_in     - almost-full threshold to program
//                thr_ae_in     - almost-empty threshold to program
//                fifo_empty    - per-lane FIFO empty flags
//                fifo_error    - per-lane FIFO overflow/underflow flags
//                selector_IDLE - recirculator selector, 1 in IDLE
//                thr_af_out    - programmed almost-full threshold
//                thr_ae_out    - programmed almost-empty threshold
//                state_out     - current state encoding
//                error_out     - 1 in ERROR
//                err_lane      - sticky per-lane error record
// ---------------------------------------------------------------------------
module recirc_fsm
  import recirc_pkg::*;
#(
  parameter int THR_W     = RECIRC_THR_W,
  parameter int IDLE_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    init,
  input  logic [THR_W-1:0]        thr_af_in,
  input  logic [THR_W-1:0]        thr_ae_in,
  input  logic [RECIRC_LANES-1:0] fifo_empty,
  input  logic [RECIRC_LANES-1:0] fifo_error,
  output logic                    selector_IDLE,
  output logic [THR_W-1:0]        thr_af_out,
  output logic [THR_W-1:0]        thr_ae_out,
  output logic [2:0]              state_out,
  output logic                    error_out,
  output logic [RECIRC_LANES-1:0] err_lane
);

  // A zero-length debounce has no meaning; stop elaboration early.
  if (IDLE_HOLD < 1) begin : gBadHold
    $error("recirc_fsm: IDLE_HOLD must be at least 1");
  end

  recircState_e state;
  recircState_e nextState;
  logic         allEmpty;
  logic         anyError;
  logic         holdDone;

  assign allEmpty = (fifo_empty == {RECIRC_LANES{1'b1}});
  assign anyError = |fifo_error;

`ifdef RECIRC_IDLE_DEBOUNCE_EN
  idle_debounce #(
    .HOLD     (IDLE_HOLD)
  ) uIdleDebounce (
    .clk      (clk),
    .reset_L  (reset_L),
    .active   (state == ST_ACTIVE),
    .allEmpty (allEmpty),
    .holdDone (holdDone)
  );
`else
  assign holdDone = allEmpty;
`endif

  // Next-state selection. Errors outrank init, which outranks the normal
  // drain/fill transitions; RESET always advances to INIT and ERROR only
  // leaves through reset_L.
  always_comb begin
    nextState = state;
    if (state == ST_RESET) begin
      nextState = ST_INIT;
    end else if (anyError) begin
      nextState = ST_ERROR;
    end else begin
      case (state)
        ST_INIT: begin
          if (!init) begin
            nextState = (thr_ae_in < thr_af_in) ? ST_IDLE : ST_ERROR;
          end
        end
        ST_IDLE: begin
          if (init) begin
            nextState = ST_INIT;
          end else if (!allEmpty) begin
            nextState = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (init) begin
            nextState = ST_INIT;
          end else if (holdDone) begin
            nextState = ST_IDLE;
          end
        end
        ST_ERROR: nextState = ST_ERROR;
        default:  nextState = ST_RESET;
      endcase
    end
  end

  // State plus every output is registered here, each output decoded from the
  // state being entered so it always matches the state register. Thresholds
  // follow the inputs on every edge spent in INIT, including the leaving edge.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state         <= ST_RESET;
      selector_IDLE <= 1'b0;
      thr_af_out    <= '0;
      thr_ae_out    <= '0;
      state_out     <= 3'd0;
      error_out     <= 1'b0;
      err_lane      <= '0;
    end else begin
      state         <= nextState;
      selector_IDLE <= (nextState == ST_IDLE);
      state_out     <= nextState;
      error_out     <= (nextState == ST_ERROR);
      if (state == ST_INIT) begin
        thr_af_out <= thr_af_in;
        thr_ae_out <= thr_ae_in;
      end
      if (state != ST_RESET) begin
        err_lane <= err_lane | fifo_error;
      end
    end
  end

endmodule : recirc_fsm

// File: tb/tb_recirc_fsm.sv
// ---------------------------------------------------------------------------
// tb_recirc_fsm
//   Self-checking bench for recirc_fsm: directed scenarios followed by
//   randomized traffic, every output compared against a behavioural model
//   after each clock edge. Honours RECIRC_IDLE_DEBOUNCE_EN for the expected
//   ACTIVE->IDLE delay.
// ---------------------------------------------------------------------------
module tb_recirc_fsm;

  localparam int THR_W = 3;
`ifdef RECIRC_IDLE_DEBOUNCE_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 1;
`endif

  localparam int M_RESET  = 0;
  localparam int M_INIT   = 1;
  localparam int M_IDLE   = 2;
  localparam int M_ACTIVE = 3;
  localparam int M_ERROR  = 4;

  logic             clk;
  logic             reset_L;
  logic             init;
  logic [THR_W-1:0] thr_af_in;
  logic [THR_W-1:0] thr_ae_in;
  logic [3:0]       fifo_empty;
  logic [3:0]       fifo_error;
  logic             selector_IDLE;
  logic [THR_W-1:0] thr_af_out;
  logic [THR_W-1:0] thr_ae_out;
  logic [2:0]       state_out;
  logic             error_out;
  logic [3:0]       err_lane;

  int vectorCount = 0;
  int missCount   = 0;

  // Behavioural model state
  int       mState;
  int       mAf;
  int       mAe;
  int       mErr;
  int       mRun;

  recirc_fsm #(
    .THR_W         (THR_W),
    .IDLE_HOLD     (4)
  ) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .init          (init),
    .thr_af_in     (thr_af_in),
    .thr_ae_in     (thr_ae_in),
    .fifo_empty    (fifo_empty),
    .fifo_error    (fifo_error),
    .selector_IDLE (selector_IDLE),
    .thr_af_out    (thr_af_out),
    .thr_ae_out    (thr_ae_out),
    .state_out     (state_out),
    .error_out     (error_out),
    .err_lane      (err_lane)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Model of one clock edge, written from the rules: errors stick and win,
  // init re-enters INIT from IDLE/ACTIVE, thresholds load on INIT edges, and
  // ACTIVE drains back to IDLE after HOLD empty edges in a row.
  task automatic modelStep();
    int prev;
    if (!reset_L) begin
      mState = M_RESET; mAf = 0; mAe = 0; mErr = 0; mRun = 0;
      return;
    end
    prev = mState;
    if (prev == M_INIT) begin
      mAf = int'(thr_af_in);
      mAe = int'(thr_ae_in);
    end
    if (prev == M_RESET) begin
      mState = M_INIT;
    end else if (fifo_error != 4'h0) begin
      mErr   = mErr | int'(fifo_error);
      mState = M_ERROR;
    end else if (prev == M_ERROR) begin
      mState = M_ERROR;
    end else if (init && (prev == M_IDLE || prev == M_ACTIVE)) begin
      mState = M_INIT;
    end else if (prev == M_INIT && !init) begin
      mState = (thr_ae_in < thr_af_in) ? M_IDLE : M_ERROR;
    end else if (prev == M_IDLE && fifo_empty != 4'hF) begin
      mState = M_ACTIVE;
    end else if (prev == M_ACTIVE) begin
      if (fifo_empty == 4'hF) begin
        mRun++;
        if (mRun >= HOLD) mState = M_IDLE;
      end else begin
        mRun = 0;
      end
    end
    if (mState != M_ACTIVE) mRun = 0;
  endtask

  task automatic compareAll();
    checkOutput("state_out",     32'(state_out),     32'(mState));
    checkOutput("selector_IDLE", 32'(selector_IDLE), 32'(mState == M_IDLE));
    checkOutput("error_out",     32'(error_out),     32'(mState == M_ERROR));
    checkOutput("thr_af_out",    32'(thr_af_out),    32'(mAf));
    checkOutput("thr_ae_out",    32'(thr_ae_out),    32'(mAe));
    checkOutput("err_lane",      32'(err_lane),      32'(mErr));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check after it
  task automatic applyStimulus(input logic rst, input logic ini,
                               input logic [THR_W-1:0] af,
                               input logic [THR_W-1:0] ae,
                               input logic [3:0] empty,
                               input logic [3:0] err);
    reset_L    = rst;
    init       = ini;
    thr_af_in  = af;
    thr_ae_in  = ae;
    fifo_empty = empty;
    fifo_error = err;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  // Reset, then RESET->INIT->IDLE with the given thresholds
  task automatic bringUp(input logic [THR_W-1:0] af,
                         input logic [THR_W-1:0] ae);
    applyStimulus(1'b0, 1'b0, af, ae, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b1, af, ae, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b0, af, ae, 4'hF, 4'h0);
  endtask

  initial begin
    logic [3:0] glitchSeq [8];
    mState = M_RESET; mAf = 0; mAe = 0; mErr = 0; mRun = 0;
    reset_L = 1'b0; init = 1'b0; thr_af_in = '0; thr_ae_in = '0;
    fifo_empty = 4'hF; fifo_error = 4'h0;

    // Reset held two cycles, then program 6/2 and drop init
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 4'hF, 4'h0);
    applyStimulus(1'b0, 1'b1, 3'd6, 3'd2, 4'hF, 4'h0);
    checkOutput("resetState", 32'(state_out), 32'd0);
    applyStimulus(1'b1, 1'b1, 3'd6, 3'd2, 4'hF, 4'h0);
    checkOutput("initState", 32'(state_out), 32'd1);
    applyStimulus(1'b1, 1'b1, 3'd6, 3'd2, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b0, 3'd6, 3'd2, 4'hF, 4'h0);
    checkOutput("idleState", 32'(state_out), 32'd2);
    checkOutput("idleSel",   32'(selector_IDLE), 32'd1);
    checkOutput("afProgram", 32'(thr_af_out), 32'd6);
    checkOutput("aeProgram", 32'(thr_ae_out), 32'd2);

    // Fill one lane, then drain with a 4'hB glitch on the third empty cycle
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 4'hE, 4'h0);
    checkOutput("activeState", 32'(state_out), 32'd3);
    checkOutput("activeSel",   32'(selector_IDLE), 32'd0);
    glitchSeq = '{4'hF, 4'hF, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    foreach (glitchSeq[i]) applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, glitchSeq[i], 4'h0);
    checkOutput("drainedIdle", 32'(state_out), 32'd2);

    // Clean drain: four all-empty cycles after filling
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 4'h7, 4'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 4'hF, 4'h0);
    checkOutput("cleanDrain", 32'(state_out), 32'd2);

    // Equal thresholds are illegal: INIT -> ERROR without lane errors
    applyStimulus(1'b1, 1'b1, 3'd5, 3'd5, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b1, 3'd5, 3'd5, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b0, 3'd5, 3'd5, 4'hF, 4'h0);
    checkOutput("badThrError", 32'(error_out), 32'd1);
    checkOutput("badThrLanes", 32'(err_lane), 32'd0);

    // Lane errors in ACTIVE accumulate; init cannot leave ERROR
    bringUp(3'd7, 3'd1);
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 4'hD, 4'h0);
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 4'hD, 4'h4);
    checkOutput("lane2Error", 32'(err_lane), 32'h4);
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 4'hD, 4'h0);
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 4'hF, 4'h1);
    checkOutput("lane0Error", 32'(err_lane), 32'h5);
    applyStimulus(1'b1, 1'b1, 3'd3, 3'd1, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b1, 3'd3, 3'd1, 4'hF, 4'h0);
    checkOutput("errorSticky", 32'(state_out), 32'd4);

    // init and fifo_error together in IDLE: error wins
    bringUp(3'd4, 3'd3);
    applyStimulus(1'b1, 1'b1, 3'd0, 3'd0, 4'hF, 4'h2);
    checkOutput("errBeatsInit", 32'(state_out), 32'd4);
    checkOutput("errBeatsLane", 32'(err_lane), 32'h2);

    // Reset in the middle of ACTIVE
    bringUp(3'd6, 3'd3);
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0);
    checkOutput("midResetState", 32'(state_out), 32'd0);
    checkOutput("midResetAf",    32'(thr_af_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 3'd5, 3'd1, 4'h3, 4'h8);

    // Randomized traffic, biased toward mostly-empty lanes and rare faults
    for (int i = 0; i < 600; i++) begin
      logic             rRst;
      logic             rInit;
      logic [3:0]       rEmpty;
      logic [3:0]       rErr;
      logic [THR_W-1:0] rAf;
      logic [THR_W-1:0] rAe;
      rRst   = ($urandom_range(0, 29) != 0);
      rInit  = ($urandom_range(0, 11) == 0);
      rErr   = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      rEmpty = ($urandom_range(0, 9) < 6) ? 4'hF : 4'($urandom);
      rAf    = THR_W'($urandom);
      rAe    = THR_W'($urandom);
      applyStimulus(rRst, rInit, rAf, rAe, rEmpty, rErr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule : tb_recirc_fsm

// File: doc/recirc_fsm.md
RECIRC_FSM -- requirements
Module: recirc_fsm

Interface
REQ-001 SHALL have parameter: THR_W, 3, width of FIFO almost-full/almost-empty thresholds.
REQ-002 SHALL have parameter: IDLE_HOLD, 4, consecutive all-empty cycles required before ACTIVE->IDLE (used only with RECIRC_IDLE_DEBOUNCE_EN).
REQ-003 SHALL have port: clk  in  1  single clock, all state updates on posedge.
REQ-004 SHALL have port: reset_L  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port: init  in  1  request to enter or stay in INIT and program thresholds.
REQ-006 SHALL have port: thr_af_in  in  THR_W  almost-full threshold to program.
REQ-007 SHALL have port: thr_ae_in  in  THR_W  almost-empty threshold to program.
REQ-008 SHALL have port: fifo_empty  in  4  per-lane FIFO empty flags.
REQ-009 SHALL have port: fifo_error  in  4  per-lane FIFO overflow/underflow flags.
REQ-010 SHALL have port: selector_IDLE  out  1  drives the recirculator selector; 1 iff state is IDLE.
REQ-011 SHALL have port: thr_af_out  out  THR_W  programmed almost-full threshold.
REQ-012 SHALL have port: thr_ae_out  out  THR_W  programmed almost-empty threshold.
REQ-013 SHALL have port: state_out  out  3  current state encoding.
REQ-014 SHALL have port: error_out  out  1  1 iff state is ERROR.
REQ-015 SHALL have port: err_lane  out  4  sticky per-lane error record.

Function
REQ-016 SHALL implement a Moore FSM with states RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; all outputs are decoded from registered state, so they change one cycle after the input condition is sampled.
REQ-017 SHALL apply transition priority reset_L low > fifo_error != 0 > init high > normal transitions.
REQ-018 SHALL move RESET->INIT on the first edge with reset_L high.
REQ-019 SHALL capture thr_af_in/thr_ae_in into thr_af_out/thr_ae_out on every edge while in INIT, and hold them in all other states.
REQ-020 SHALL move INIT->IDLE when init is low and thr_ae_in < thr_af_in; when init is low and thr_ae_in >= thr_af_in, it SHALL move INIT->ERROR with err_lane unchanged.
REQ-021 SHALL move IDLE->ACTIVE when any fifo_empty bit is 0.
REQ-022 SHALL move ACTIVE->IDLE when fifo_empty==4'hF (immediately, or after the debounce in REQ-030).
REQ-023 SHALL move IDLE or ACTIVE to INIT when init is high and no fifo_error bit is set.
REQ-024 SHALL move any state except RESET to ERROR when any fifo_error bit is 1, and OR fifo_error into err_lane on that edge.
REQ-025 SHALL keep ERROR until reset_L is low; init and fifo_empty SHALL be ignored in ERROR, while new fifo_error bits are still ORed into err_lane.
REQ-026 SHALL, for simultaneous init high and fifo_error != 0, go to ERROR.

Reset
REQ-027 SHALL, on an edge with reset_L low, set state=RESET, selector_IDLE=0, thr_af_out=0, thr_ae_out=0, state_out=0, error_out=0, err_lane=0, and debounce counter=0, regardless of current state (including mid-ACTIVE and ERROR).
REQ-028 SHALL produce no output change other than reset values while reset_L stays low.

Configuration
REQ-029 SHALL use macro RECIRC_IDLE_DEBOUNCE_EN to enable an ACTIVE->IDLE debounce counter.
REQ-030 SHALL, with RECIRC_IDLE_DEBOUNCE_EN defined, count consecutive edges in ACTIVE with fifo_empty==4'hF (saturating, cleared on any non-empty lane or on leaving ACTIVE), and transition to IDLE on the IDLE_HOLD-th such edge.
REQ-031 SHALL, without RECIRC_IDLE_DEBOUNCE_EN, omit the counter and transition on the first all-empty edge.

Structure
REQ-032 SHALL place the state encodings and the default THR_W in shared package recirc_pkg.
REQ-033 SHALL implement the debounce as sub-module idle_debounce, instantiated only under RECIRC_IDLE_DEBOUNCE_EN.

Verification
REQ-034 SHALL cover: reset_L low 2 cycles, then high with init=1, thr_af_in=6, thr_ae_in=2, then init=0 -> states RESET, INIT, IDLE; thr_af_out=6, thr_ae_out=2; selector_IDLE=1 in IDLE.
REQ-035 SHALL cover: in IDLE, fifo_empty=4'hE -> ACTIVE and selector_IDLE=0 next cycle; fifo_empty=4'hF for 4 cycles -> IDLE after 1 cycle (macro off) or after 4 cycles (macro on, IDLE_HOLD=4); a 4'hB glitch on the 3rd cycle restarts the count.
REQ-036 SHALL cover: in INIT, thr_ae_in=5, thr_af_in=5, init falls -> ERROR, error_out=1, err_lane=0.
REQ-037 SHALL cover: in ACTIVE, fifo_error=4'h4 for 1 cycle -> ERROR, err_lane=4'h4; later fifo_error=4'h1 -> err_lane=4'h5; init=1 keeps ERROR.
REQ-038 SHALL cover: init=1 and fifo_error=4'h2 on the same edge in IDLE -> ERROR, err_lane=4'h2.
REQ-039 SHALL cover: reset_L low mid-ACTIVE with thresholds programmed -> all outputs return to reset values on the next edge.
